// File: rtl/mem_master_pkg.sv
// Shared types and counter widths for the RAM bus master.
package mem_master_pkg;

    // Bus master sequencing states; VRD is only reachable when write
    // verification is compiled in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        TA   = 3'd2,
        RD   = 3'd3,
        VRD  = 3'd4,
        RSP  = 3'd5
    } state_t;

    // Read wait states span 0..15, turnaround cycles span 0..3.
    localparam int WAIT_CNT_W = 4;
    localparam int TA_CNT_W   = 2;

endpackage

// File: rtl/bus_tristate_buf.sv
// Tristate pad for the shared RAM data bus. Keeps the 'z drive out of the
// sequencing logic so the FSM is plain synchronous logic.
module bus_tristate_buf #(
    parameter int WIDTH = 4
) (
    input  logic             drive_en,
    input  logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_in,
    inout  wire  [WIDTH-1:0] pad
);

    assign pad     = drive_en ? data_out : {WIDTH{1'bz}};
    assign data_in = pad;

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator for a single-port RAM on a shared tristate data bus.
// Takes one read/write request at a time over valid/ready, sequences
// mem_wen/mem_addr/mem_data with read wait states and write turnaround,
// and returns exactly one response per request.
// Optional feature: define MEM_MASTER_WRITE_VERIFY_EN to read back every
// write and flag a mismatch on rsp_err.
module mem_bus_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int READ_WAIT  = 0,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    // Counter preloads: a phase lasting N cycles loads N-1 and leaves at zero.
    localparam logic [WAIT_CNT_W-1:0] RW_LOAD = WAIT_CNT_W'(READ_WAIT);
    localparam logic [TA_CNT_W-1:0]   TA_LOAD =
        (TURNAROUND > 0) ? TA_CNT_W'(TURNAROUND - 1) : '0;

    // Where a write goes once the bus has been turned around.
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    localparam state_t AFTER_WR = VRD;
`else
    localparam state_t AFTER_WR = RSP;
`endif

    state_t                  state_q,     state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    mem_wen_q,   mem_wen_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [WAIT_CNT_W-1:0]   cnt_q,       cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    logic                    rsp_err_q,   rsp_err_d;
`endif
    logic [DATA_WIDTH-1:0]   bus_in;

    // Drive enable is the registered write enable, so the RAM (which drives
    // only while mem_wen is low) and the master never fight over the bus.
    bus_tristate_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_bus_buf (
        .drive_en (mem_wen_q),
        .data_out (wdata_q),
        .data_in  (bus_in),
        .pad      (mem_data)
    );

    // Next-state and next-output logic for the request/response sequencer.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mem_addr_d  = req_addr;
                    wdata_d     = req_wdata;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
                    rsp_err_d   = 1'b0;
`endif
                    if (req_we) begin
                        mem_wen_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = WR;
                    end else begin
                        cnt_d   = RW_LOAD;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                // The RAM stores on this edge; release the bus right after.
                mem_wen_d = 1'b0;
                if (TURNAROUND > 0) begin
                    cnt_d   = WAIT_CNT_W'(TA_LOAD);
                    state_d = TA;
                end else begin
                    cnt_d       = RW_LOAD;
                    rsp_valid_d = (AFTER_WR == RSP);
                    state_d     = AFTER_WR;
                end
            end
            TA: begin
                if (cnt_q == '0) begin
                    cnt_d       = RW_LOAD;
                    rsp_valid_d = (AFTER_WR == RSP);
                    state_d     = AFTER_WR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = bus_in;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            VRD: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = bus_in;
                    rsp_err_d   = (bus_in != wdata_q);
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            RSP: begin
                // Ready rises only after the handshake edge: one bubble cycle.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                mem_wen_d   = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q & rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master. Two instances, each with its own
// behavioural RAM: instance 0 uses READ_WAIT=0/TURNAROUND=1, instance 1
// uses READ_WAIT=2/TURNAROUND=0.
module tb_mem_bus_master;

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Accept-to-valid latency for writes on each instance.
    localparam int WR_LAT0 = VERIFY ? 3 : 2;
    localparam int WR_LAT1 = VERIFY ? 4 : 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic corrupt_wr = 1'b0;

    logic [1:0]      req_valid = '0;
    logic [1:0]      req_we    = '0;
    logic [1:0]      rsp_ready = '0;
    logic [1:0][3:0] req_addr  = '0;
    logic [1:0][3:0] req_wdata = '0;

    wire  [1:0]      req_ready;
    wire  [1:0]      rsp_valid;
    wire  [1:0]      rsp_err;
    wire  [1:0]      mem_wen;
    wire  [1:0][3:0] rsp_rdata;
    wire  [1:0][3:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wire  [3:0] bus;
        logic [3:0] ram [16];

        mem_bus_master #(
            .ADDR_WIDTH (4),
            .DATA_WIDTH (4),
            .READ_WAIT  ((gi == 0) ? 0 : 2),
            .TURNAROUND ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_rdata (rsp_rdata[gi]),
            .rsp_err   (rsp_err[gi]),
            .mem_wen   (mem_wen[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_data  (bus)
        );

        // RAM drives the bus whenever the master is not writing.
        assign bus = mem_wen[gi] ? 4'bzzzz : ram[mem_addr[gi]];

        always @(posedge clk) begin
            if (mem_wen[gi])
                ram[mem_addr[gi]] <= (corrupt_wr && gi == 0) ? 4'h4 : bus;
        end
    end

    // One full transaction with rsp_ready assumed high; returns what was seen.
    task automatic do_req(input int d, input logic we, input logic [3:0] addr,
                          input logic [3:0] wdata, output int lat,
                          output logic [3:0] rdata, output logic err);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        $display("txn dut%0d %s addr=%h wdata=%h lat=%0d rdata=%h err=%b",
                 d, we ? "WR" : "RD", addr, wdata, lat, rdata, err);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mem_wen !== 2'b00) begin n_fail++; $display("FAIL reset_wen got=%b exp=00", mem_wen); end
        n_checks++;
        if (mem_addr[0] !== 4'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_addr[0]); end
        n_checks++;
        if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        n_checks++;
        if (rsp_rdata[0] !== 4'h0 || rsp_err[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp got rdata=%h err=%b exp 0/0", rsp_rdata[0], rsp_err[0]);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b exp=11", req_ready); end
    endtask

    task automatic test_write_read();
        int lat; logic [3:0] rd; logic er;
        rsp_ready = 2'b11;
        do_req(0, 1'b1, 4'h3, 4'hA, lat, rd, er);
        n_checks++;
        if (lat != WR_LAT0) begin n_fail++; $display("FAIL wr_lat got=%0d exp=%0d", lat, WR_LAT0); end
        n_checks++;
        if (rd !== (VERIFY ? 4'hA : 4'h0) || er !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp got rdata=%h err=%b exp=%h/0", rd, er, VERIFY ? 4'hA : 4'h0);
        end
        do_req(0, 1'b0, 4'h3, 4'h0, lat, rd, er);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL rd_lat got=%0d exp=1", lat); end
        n_checks++;
        if (rd !== 4'hA || er !== 1'b0) begin n_fail++; $display("FAIL rd_data got=%h err=%b exp=a/0", rd, er); end
    endtask

    task automatic test_back_pressure();
        int lat; logic [3:0] rd; logic er;
        do_req(0, 1'b1, 4'h5, 4'h6, lat, rd, er);
        rsp_ready[0] = 1'b0;
        req_we[0] = 1'b0; req_addr[0] = 4'h5; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        // A second request waits on the bus while the first is stalled.
        req_addr[0] = 4'h3;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_rd got=%b exp=0", req_ready[0]); end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 4'h6) begin
            n_fail++; $display("FAIL bp_first got valid=%b rdata=%h exp=1/6", rsp_valid[0], rsp_rdata[0]);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 4'h6 || req_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b exp=1/6/0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        $display("txn dut0 RD addr=5 backpressured rdata=6 released");
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_bubble got valid=%b ready=%b exp=0/1", rsp_valid[0], req_ready[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got ready=%b exp=0", req_ready[0]); end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 4'hA) begin
            n_fail++; $display("FAIL bp_second got valid=%b rdata=%h exp=1/a", rsp_valid[0], rsp_rdata[0]);
        end
        $display("txn dut0 RD addr=3 after bubble rdata=%h", rsp_rdata[0]);
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        int lat; logic [3:0] rd; logic er;
        do_req(1, 1'b1, 4'h7, 4'h1, lat, rd, er);
        n_checks++;
        if (lat != WR_LAT1) begin n_fail++; $display("FAIL ws_wr_lat got=%0d exp=%0d", lat, WR_LAT1); end
        do_req(1, 1'b0, 4'h7, 4'h0, lat, rd, er);
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL ws_rd_lat got=%0d exp=3", lat); end
        n_checks++;
        if (rd !== 4'h1) begin n_fail++; $display("FAIL ws_rd_data got=%h exp=1", rd); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [3:0] rd; logic er; logic [3:0] kept;
        do_req(0, 1'b1, 4'h9, 4'h3, lat, rd, er);
        req_we[0] = 1'b1; req_addr[0] = 4'h9; req_wdata[0] = 4'hC; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (mem_wen[0] !== 1'b1) begin n_fail++; $display("FAIL rmw_in_wr got wen=%b exp=1", mem_wen[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_wen[0] !== 1'b0 || mem_addr[0] !== 4'h0) begin
            n_fail++; $display("FAIL rmw_async got wen=%b addr=%h exp=0/0", mem_wen[0], mem_addr[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rmw_no_rsp%0d got valid=%b exp=0", i, rsp_valid[0]); end
        end
        kept = g_dut[0].ram[9];
        $display("txn dut0 WR addr=9 wdata=c aborted by reset ram=%h", kept);
        n_checks++;
        if (kept !== 4'h3 && kept !== 4'hC) begin n_fail++; $display("FAIL rmw_ram got=%h exp=3 or c", kept); end
        do_req(0, 1'b0, 4'h9, 4'h0, lat, rd, er);
        n_checks++;
        if (rd !== kept || lat != 1) begin n_fail++; $display("FAIL rmw_readback got=%h lat=%0d exp=%h/1", rd, lat, kept); end
    endtask

`ifdef MEM_MASTER_WRITE_VERIFY_EN
    task automatic test_write_verify();
        int lat; logic [3:0] rd; logic er;
        corrupt_wr = 1'b1;
        do_req(0, 1'b1, 4'h2, 4'h5, lat, rd, er);
        corrupt_wr = 1'b0;
        n_checks++;
        if (er !== 1'b1 || rd !== 4'h4) begin n_fail++; $display("FAIL wv_bad got err=%b rdata=%h exp=1/4", er, rd); end
        do_req(0, 1'b1, 4'h2, 4'h5, lat, rd, er);
        n_checks++;
        if (er !== 1'b0 || rd !== 4'h5 || lat != 3) begin
            n_fail++; $display("FAIL wv_good got err=%b rdata=%h lat=%0d exp=0/5/3", er, rd, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_pressure();
        test_wait_states();
        test_reset_mid_write();
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        test_write_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
